// File: rtl/parity_serial_tx.sv
// ---------------------------------------------------------------------------
// parity_serial_tx
//
// Serial transmitter with a small write FIFO. Each byte written by the CPU
// store path is sent LSB-first as an 11-bit frame:
//   start(0), d[0]..d[7], parity, stop(1)
// Each bit is held for CLKS_PER_BIT clock cycles. By default the parity bit
// makes the 9 bits {d, p} carry an even number of ones.
//
// Build option:
//   PARITY_TX_ODD_PARITY_EN  when defined, the parity bit makes {d, p} carry
//                            an odd number of ones. Timing is unchanged.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte entries in the write FIFO (power of two, >= 2)
//
// Ports:
//   clock    system clock, rising edge
//   resetn   asynchronous active-low reset
//   wr_en    write strobe, one byte per asserted cycle
//   wr_data  byte to transmit
//   clr_ovf  clears the sticky overflow flag
//   txd      registered serial line, idle high
//   busy     high while a frame is on the line
//   full     FIFO holds FIFO_DEPTH entries
//   empty    FIFO holds no entries
//   level    current FIFO occupancy
//   ovf      sticky flag: a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module parity_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_ovf,
    output logic                          txd,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push;
    logic          pop;

    // Transmit FSM
    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          txd_q;
    logic          busy_q;
    logic          ovf_q;
    logic          bit_done;
    logic [7:0]    head;

    function automatic logic frame_parity(input logic [7:0] d);
`ifdef PARITY_TX_ODD_PARITY_EN
        return ~(^d);
`else
        return ^d;
`endif
    endfunction

    assign full     = (count_q == DEPTH_L);
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;
    assign head     = mem_q[rd_ptr_q];
    assign bit_done = (baud_q == BAUD_LAST);

    // A write is judged against 'full' before the edge, so a same-cycle pop
    // never makes room for it.
    assign push = wr_en && !full;
    // The FSM takes the next byte either from idle or on the last stop cycle,
    // which gives back-to-back frames without an idle gap.
    assign pop  = !empty && ((state_q == IDLE) || (state_q == STOP && bit_done));

    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            // Set has priority over clear.
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            // Baud counter runs in every non-idle state and restarts on each bit boundary.
            if (state_q != IDLE) begin
                baud_q <= bit_done ? '0 : baud_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q  <= head;
                        parity_q <= frame_parity(head);
                        txd_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= parity_q;
                            state_q <= PARITY;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            txd_q     <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        txd_q   <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift_q  <= head;
                            parity_q <= frame_parity(head);
                            txd_q    <= 1'b0;
                            state_q  <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
